// File: rtl/rv32i_types.sv
// Shared types for the dispatch controller: FSM state encoding and default ROB slot id.
package rv32i_types;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } dispatch_ctrl_state_t;

  localparam int ROB_ENTRIES_DFLT = 16;

  typedef logic [$clog2(ROB_ENTRIES_DFLT)-1:0] rob_id_t;

endpackage

// File: rtl/dispatch_ctrl_chk.sv
// Flags a retirement count larger than the current ROB occupancy.
module dispatch_ctrl_chk #(
  parameter int CNTW = 5,
  parameter int CCW  = 2
) (
  input logic            clk,
  input logic            rst,
  input logic [CCW-1:0]  commit_cnt,
  input logic [CNTW-1:0] rob_count
);

  commit_le_count: assert property (@(posedge clk) disable iff (rst)
    CNTW'(commit_cnt) <= rob_count);

endmodule

// File: rtl/rob_alloc_counter.sv
// ROB occupancy and tail pointer; flush empties the ROB and rewinds the tail.
module rob_alloc_counter #(
  parameter int SS          = 2,
  parameter int ROB_ENTRIES = 16,
  localparam int IDW  = $clog2(ROB_ENTRIES),
  localparam int CNTW = $clog2(ROB_ENTRIES + 1),
  localparam int CCW  = $clog2(SS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            pop,
  input  logic [CCW-1:0]  commit_cnt,
  output logic [CNTW-1:0] rob_count,
  output logic [IDW-1:0]  tail,
  output logic            room
);

  localparam logic [CNTW:0]   SS_X  = SS[CNTW:0];
  localparam logic [CNTW:0]   LIMIT = ROB_ENTRIES[CNTW:0];
  localparam logic [CNTW-1:0] SS_C  = SS[CNTW-1:0];
  localparam logic [IDW-1:0]  SS_I  = SS[IDW-1:0];

  logic [CNTW-1:0] commit_ext;

  assign commit_ext = {{(CNTW-CCW){1'b0}}, commit_cnt};
  // one extra bit so rob_count + SS cannot overflow before the compare
  assign room = ({1'b0, rob_count} + SS_X) <= LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_count <= '0;
      tail      <= '0;
    end else if (flush) begin
      rob_count <= '0;
      tail      <= '0;
    end else begin
      rob_count <= rob_count + (pop ? SS_C : {CNTW{1'b0}}) - commit_ext;
      if (pop) begin
        tail <= tail + SS_I;
      end else begin
        tail <= tail;
      end
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Rename/dispatch handshake FSM with ROB slot and RVFI order assignment.
// Optional stall counters are built when DISPATCH_CTRL_PERF_EN is defined.
module dispatch_ctrl
  import rv32i_types::*;
#(
  parameter int SS          = 2,
  parameter int ROB_ENTRIES = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      inst_q_empty,
  input  logic                                      rs_full,
  input  logic                                      free_list_empty,
  input  logic [$clog2(SS+1)-1:0]                   commit_cnt,
  input  logic                                      flush,
  output logic                                      pop_inst_q,
  output logic                                      dispatch_valid,
  output logic [SS-1:0][$clog2(ROB_ENTRIES)-1:0]    rob_id,
  output logic [SS-1:0][63:0]                       order
`ifdef DISPATCH_CTRL_PERF_EN
  ,
  output logic [31:0]                               stall_rs_cycles,
  output logic [31:0]                               stall_rob_cycles,
  output logic [31:0]                               stall_fl_cycles
`endif
);

  localparam int IDW  = $clog2(ROB_ENTRIES);
  localparam int CNTW = $clog2(ROB_ENTRIES + 1);
  localparam int CCW  = $clog2(SS + 1);
  localparam logic [63:0] SS_64 = 64'(SS);

  dispatch_ctrl_state_t state;
  logic [63:0]          order_base;
  logic [63:0]          commit_order;
  logic [63:0]          commit_ext;
  logic [CNTW-1:0]      rob_count;
  logic [IDW-1:0]       tail;
  logic                 room;

  assign commit_ext = {{(64-CCW){1'b0}}, commit_cnt};
  assign pop_inst_q = !rst && (state == RUN) && !flush && !inst_q_empty &&
                      !rs_full && !free_list_empty && room;

  rob_alloc_counter #(.SS(SS), .ROB_ENTRIES(ROB_ENTRIES)) u_rob_alloc (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .pop        (pop_inst_q),
    .commit_cnt (commit_cnt),
    .rob_count  (rob_count),
    .tail       (tail),
    .room       (room)
  );

  dispatch_ctrl_chk #(.CNTW(CNTW), .CCW(CCW)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .commit_cnt (commit_cnt),
    .rob_count  (rob_count)
  );

  // pop is already 0 in a flush cycle, so dispatch_valid drops after it for free
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      dispatch_valid <= 1'b0;
      rob_id         <= '0;
      order          <= '0;
      order_base     <= 64'd0;
      commit_order   <= 64'd0;
    end else begin
      commit_order   <= commit_order + commit_ext;
      dispatch_valid <= pop_inst_q;
      if (flush) begin
        state      <= FLUSH;
        order_base <= commit_order + commit_ext;
      end else begin
        case (state)
          RUN:     state <= RUN;
          FLUSH:   state <= RECOVER;
          RECOVER: state <= RUN;
          default: state <= RUN;
        endcase
        if (pop_inst_q) begin
          for (int i = 0; i < SS; i++) begin
            rob_id[i] <= tail + i[IDW-1:0];
            order[i]  <= order_base + 64'(i);
          end
          order_base <= order_base + SS_64;
        end else begin
          order_base <= order_base;
        end
      end
    end
  end

`ifdef DISPATCH_CTRL_PERF_EN
  logic stall_active;
  assign stall_active = !rst && (state == RUN) && !flush && !inst_q_empty;

  // only the first blocker in rs, rob, fl priority is charged for a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_rs_cycles  <= 32'd0;
      stall_rob_cycles <= 32'd0;
      stall_fl_cycles  <= 32'd0;
    end else if (stall_active && rs_full) begin
      if (stall_rs_cycles != 32'hFFFF_FFFF) stall_rs_cycles <= stall_rs_cycles + 32'd1;
    end else if (stall_active && !room) begin
      if (stall_rob_cycles != 32'hFFFF_FFFF) stall_rob_cycles <= stall_rob_cycles + 32'd1;
    end else if (stall_active && free_list_empty) begin
      if (stall_fl_cycles != 32'hFFFF_FFFF) stall_fl_cycles <= stall_fl_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural dispatch model.
module tb_dispatch_ctrl;

  localparam int SS  = 2;
  localparam int ROB = 16;

  logic clk = 1'b0;
  logic rst, inst_q_empty, rs_full, free_list_empty, flush;
  logic [1:0] commit_cnt;
  logic pop_inst_q, dispatch_valid;
  logic [SS-1:0][3:0]  rob_id;
  logic [SS-1:0][63:0] order;

  dispatch_ctrl #(.SS(SS), .ROB_ENTRIES(ROB)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_q_empty    (inst_q_empty),
    .rs_full         (rs_full),
    .free_list_empty (free_list_empty),
    .commit_cnt      (commit_cnt),
    .flush           (flush),
    .pop_inst_q      (pop_inst_q),
    .dispatch_valid  (dispatch_valid),
    .rob_id          (rob_id),
    .order           (order)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // behavioural model: mode 0 = run, 1 = flushing, 2 = recovering
  int     m_mode, m_cnt, m_tail;
  longint m_base, m_co;
  bit     m_dv, m_ok;
  int     m_rid [SS];
  longint m_ord [SS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit mdl_pop();
    return !rst && m_mode == 0 && !flush && !inst_q_empty && !rs_full &&
           !free_list_empty && (m_cnt + SS <= ROB);
  endfunction

  task automatic apply(input bit r, input bit iqe, input bit rsf, input bit fle,
                       input bit fl, input int cc);
    rst = r; inst_q_empty = iqe; rs_full = rsf; free_list_empty = fle;
    flush = fl; commit_cnt = cc[1:0];
    #1;
  endtask

  task automatic compare(input bit p);
    if (m_ok) begin
      chk("pop_inst_q", {63'd0, pop_inst_q}, {63'd0, p});
      chk("dispatch_valid", {63'd0, dispatch_valid}, {63'd0, m_dv});
      for (int i = 0; i < SS; i++) begin
        chk($sformatf("rob_id[%0d]", i), {60'd0, rob_id[i]}, 64'(m_rid[i]));
        chk($sformatf("order[%0d]", i), order[i], m_ord[i]);
      end
    end
  endtask

  task automatic mdl_update(input bit p, input int cc);
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_tail = 0; m_base = 0; m_co = 0; m_dv = 0; m_ok = 1;
      for (int i = 0; i < SS; i++) begin m_rid[i] = 0; m_ord[i] = 0; end
    end else begin
      m_dv = p;
      if (p) for (int i = 0; i < SS; i++) begin
        m_rid[i] = (m_tail + i) % ROB;
        m_ord[i] = m_base + i;
      end
      if (flush) begin
        m_mode = 1; m_cnt = 0; m_tail = 0; m_base = m_co + cc;
      end else begin
        if (m_mode == 1) m_mode = 2;
        else if (m_mode == 2) m_mode = 0;
        if (p) begin m_tail = (m_tail + SS) % ROB; m_base += SS; end
        m_cnt = m_cnt + (p ? SS : 0) - cc;
      end
      m_co += cc;
    end
  endtask

  task automatic clk_step();
    bit p;
    int cc;
    p = mdl_pop();
    cc = int'(commit_cnt);
    compare(p);
    @(posedge clk);
    mdl_update(p, cc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(1, 1, 0, 0, 0, 0);
    clk_step();
  endtask

  int fl_hold;
  int cmax;

  initial begin
    m_ok = 0;
    @(negedge clk);

    // reset values, then first pop
    do_reset();
    chk("rst_dv", {63'd0, dispatch_valid}, 64'd0);
    chk("rst_rob_id", {56'd0, rob_id}, 64'd0);
    chk("rst_order0", order[0], 64'd0);
    apply(0, 0, 0, 0, 0, 0);
    chk("first_pop", {63'd0, pop_inst_q}, 64'd1);
    clk_step();
    chk("first_dv", {63'd0, dispatch_valid}, 64'd1);
    chk("first_rid0", {60'd0, rob_id[0]}, 64'd0);
    chk("first_rid1", {60'd0, rob_id[1]}, 64'd1);
    chk("first_ord1", order[1], 64'd1);

    // fill the ROB, stall, then commit to make room
    for (int n = 0; n < 7; n++) clk_step();
    chk("eighth_rid0", {60'd0, rob_id[0]}, 64'd14);
    chk("eighth_rid1", {60'd0, rob_id[1]}, 64'd15);
    chk("full_stall", {63'd0, pop_inst_q}, 64'd0);
    clk_step();
    clk_step();
    chk("stall_hold_rid", {60'd0, rob_id[1]}, 64'd15);
    apply(0, 0, 0, 0, 0, 2);
    chk("commit_cycle_pop", {63'd0, pop_inst_q}, 64'd0);
    clk_step();
    apply(0, 0, 0, 0, 0, 0);
    chk("ninth_pop", {63'd0, pop_inst_q}, 64'd1);
    clk_step();
    chk("ninth_rid0", {60'd0, rob_id[0]}, 64'd0);
    chk("ninth_rid1", {60'd0, rob_id[1]}, 64'd1);
    chk("ninth_ord0", order[0], 64'd16);

    // simultaneous pop and commit at rob_count = 14
    apply(0, 1, 0, 0, 0, 2);
    clk_step();
    apply(0, 0, 0, 0, 0, 2);
    chk("popcommit_pop", {63'd0, pop_inst_q}, 64'd1);
    clk_step();
    apply(0, 0, 0, 0, 0, 0);
    chk("popcommit_next", {63'd0, pop_inst_q}, 64'd1);
    clk_step();

    // rs_full and free_list_empty stalls
    do_reset();
    for (int n = 0; n < 3; n++) begin
      apply(0, 0, 1, 0, 0, 0);
      chk("rs_stall", {63'd0, pop_inst_q}, 64'd0);
      clk_step();
    end
    apply(0, 0, 0, 0, 0, 0);
    chk("rs_release", {63'd0, pop_inst_q}, 64'd1);
    clk_step();
    chk("rs_rid0", {60'd0, rob_id[0]}, 64'd0);
    chk("rs_ord1", order[1], 64'd1);
    for (int n = 0; n < 3; n++) begin
      apply(0, 0, 0, 1, 0, 0);
      chk("fl_stall", {63'd0, pop_inst_q}, 64'd0);
      clk_step();
    end
    apply(0, 0, 0, 0, 0, 0);
    clk_step();
    chk("fl_rid0", {60'd0, rob_id[0]}, 64'd2);
    chk("fl_ord0", order[0], 64'd2);

    // flush after five commits with a pop pending
    do_reset();
    apply(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) clk_step();
    apply(0, 1, 0, 0, 0, 2); clk_step();
    apply(0, 1, 0, 0, 0, 2); clk_step();
    apply(0, 1, 0, 0, 0, 1); clk_step();
    apply(0, 0, 0, 0, 1, 0);
    chk("flush_nopop", {63'd0, pop_inst_q}, 64'd0);
    clk_step();
    chk("flush_dv", {63'd0, dispatch_valid}, 64'd0);
    apply(0, 0, 0, 0, 1, 0);
    chk("flush2_nopop", {63'd0, pop_inst_q}, 64'd0);
    clk_step();
    apply(0, 0, 0, 0, 0, 0);
    chk("flushstate_nopop", {63'd0, pop_inst_q}, 64'd0);
    clk_step();
    chk("recover_nopop", {63'd0, pop_inst_q}, 64'd0);
    clk_step();
    chk("resume_pop", {63'd0, pop_inst_q}, 64'd1);
    clk_step();
    chk("resume_ord0", order[0], 64'd5);
    chk("resume_ord1", order[1], 64'd6);
    chk("resume_rid0", {60'd0, rob_id[0]}, 64'd0);
    chk("resume_rid1", {60'd0, rob_id[1]}, 64'd1);

    // reset while in FLUSH
    apply(0, 0, 0, 0, 1, 0); clk_step();
    apply(1, 0, 0, 0, 1, 0); clk_step();
    chk("rstflush_dv", {63'd0, dispatch_valid}, 64'd0);
    chk("rstflush_rid", {56'd0, rob_id}, 64'd0);
    chk("rstflush_ord1", order[1], 64'd0);
    apply(0, 0, 0, 0, 0, 0);
    chk("rstflush_run", {63'd0, pop_inst_q}, 64'd1);
    clk_step();

    // randomized traffic
    fl_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (fl_hold > 0) fl_hold--;
      else if ($urandom_range(0, 39) == 0) fl_hold = int'($urandom_range(1, 3));
      cmax = (m_cnt < SS) ? m_cnt : SS;
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 3,
            fl_hold > 0, int'($urandom_range(0, cmax)));
      clk_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
